ami_mem_responder: RTL

- Synthesizable single-port AMI memory responder: the responder end of the AMI request/response channel that the accelerator's block buffer drives.
- Accepts AMI read/write requests, services them from an internal word-addressed RAM, and returns read data in order through a credit-protected response FIFO.
- Used as the memory model behind the block buffer's rd/wr ports in standalone accelerator benches and as a small on-chip scratch store.

---
 rtl/ami_mem_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ami_mem_responder.sv
// AMI memory responder: word-addressed RAM cleared after reset, reads returned
// in order through a latency pipeline and a credit-protected response FIFO.
module ami_mem_responder #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MEM_DEPTH_LOG2  = 10,
    parameter int unsigned RD_LATENCY      = 4,
    parameter int unsigned RESP_FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_grant,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    input  logic              resp_grant,
    output logic              init_done,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);
    localparam int unsigned OFF_W     = $clog2(DATA_W / 8);
    localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned PTR_W     = $clog2(RESP_FIFO_DEPTH);
    localparam int unsigned CRED_W    = $clog2(RESP_FIFO_DEPTH + 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_clear_en;
    logic                        w_ready;
    logic [MEM_DEPTH_LOG2-1:0]   r_clear_idx;

    logic [DATA_W-1:0]           r_mem [MEM_DEPTH];
    logic [MEM_DEPTH_LOG2-1:0]   w_idx;
    logic                        w_accept;
    logic                        w_wr;
    logic                        w_rd;
    logic                        w_unused_addr;

    logic                        r_pv [RD_LATENCY];
    logic [DATA_W-1:0]           r_pd [RD_LATENCY];

    logic [DATA_W-1:0]           r_fifo [RESP_FIFO_DEPTH];
    logic [PTR_W:0]              r_wptr;
    logic [PTR_W:0]              r_rptr;
    logic                        r_head_v;
    logic [DATA_W-1:0]           r_head_d;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_load;
    logic                        w_st_empty;
    logic                        w_st_full;

    logic [CRED_W-1:0]           r_credit;
    logic [31:0]                 r_rd_count;
    logic [31:0]                 r_wr_count;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    // Next state: sweep every RAM word once, then serve requests until reset
    always_comb begin
        w_state_nxt = r_state;
        w_clear_en  = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clear_en = 1'b1;
                if (&r_clear_idx) w_state_nxt = ST_READY;
            end
            ST_READY: w_ready = 1'b1;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)           r_clear_idx <= '0;
        else if (w_clear_en) r_clear_idx <= r_clear_idx + MEM_DEPTH_LOG2'(1);
    end

    // Upper and byte-offset address bits are intentionally dropped
    assign w_idx         = req_addr[OFF_W +: MEM_DEPTH_LOG2];
    assign w_unused_addr = ^req_addr;

    assign req_grant = w_ready & ~reset & (r_credit < CRED_W'(RESP_FIFO_DEPTH));
    assign w_accept  = req_valid & req_grant;
    assign w_wr      = w_accept & req_is_write;
    assign w_rd      = w_accept & ~req_is_write;

    always_ff @(posedge clk) begin
        if (w_clear_en) r_mem[r_clear_idx] <= '0;
        else if (w_wr)  r_mem[w_idx]       <= req_data;
    end

    // Read latency pipeline; stage 0 captures the RAM word at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) r_pv[i] <= 1'b0;
        end else begin
            r_pv[0] <= w_rd;
            for (int i = 1; i < RD_LATENCY; i++) r_pv[i] <= r_pv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_pd[0] <= r_mem[w_idx];
        for (int i = 1; i < RD_LATENCY; i++) r_pd[i] <= r_pd[i-1];
    end

    // Response FIFO: storage ring plus a registered head entry
    assign w_push     = r_pv[RD_LATENCY-1];
    assign w_pop      = r_head_v & resp_grant;
    assign w_st_empty = (r_wptr == r_rptr);
    assign w_st_full  = ((r_wptr - r_rptr) == (PTR_W+1)'(RESP_FIFO_DEPTH));
    assign w_load     = (~r_head_v | w_pop) & ~w_st_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= r_pd[RD_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_head_v <= 1'b0;
            r_head_d <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
            if (w_load) begin
                r_rptr   <= r_rptr + (PTR_W+1)'(1);
                r_head_v <= 1'b1;
                r_head_d <= r_fifo[r_rptr[PTR_W-1:0]];
            end else if (w_pop) begin
                r_head_v <= 1'b0;
            end
        end
    end

    // Credit tracks reads in flight plus queued responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit <= '0;
        end else begin
            case ({w_rd, w_pop})
                2'b10:   r_credit <= r_credit + CRED_W'(1);
                2'b01:   r_credit <= r_credit - CRED_W'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rd) r_rd_count <= r_rd_count + 32'd1;
            if (w_wr) r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(w_push && w_st_full));

    assign resp_valid = r_head_v;
    assign resp_data  = r_head_d;
    assign init_done  = (r_state == ST_READY);
    assign rd_count   = r_rd_count;
    assign wr_count   = r_wr_count;
endmodule
